// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: four-stage multiply-accumulate with add/sub, saturation
// and rounding right shift behind a valid/ready stream.
module dsp_mac_pipe #(
  parameter int A_W      = 8,
  parameter int B_W      = 8,
  parameter int ACC_W    = 24,
  parameter int SH_W     = 4,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1,
  parameter int ROUND    = 1
) (
  input  logic             CLK,
  input  logic             a_RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   A,
  input  logic [B_W-1:0]   B,
  input  logic [ACC_W-1:0] C,
  input  logic [1:0]       OP,
  input  logic             CLR,
  input  logic [SH_W-1:0]  SH,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] O,
  output logic             OVF
);

  localparam int  P_W = A_W + B_W;
  localparam int  X_W = ACC_W + 2;
  localparam bit  SG  = (SIGNED != 0);
  localparam bit  SAT = (SATURATE != 0);
  localparam bit  RND = (ROUND != 0);

  typedef struct packed {
    logic             v;
    logic [A_W-1:0]   a;
    logic [B_W-1:0]   b;
    logic [ACC_W-1:0] c;
    logic [1:0]       op;
    logic             clr;
    logic [SH_W-1:0]  sh;
  } s1_t;

  typedef struct packed {
    logic             v;
    logic [ACC_W-1:0] p;
    logic [ACC_W-1:0] c;
    logic [1:0]       op;
    logic             clr;
    logic [SH_W-1:0]  sh;
  } s2_t;

  s1_t s1;
  s2_t s2;
  logic             v3;
  logic [SH_W-1:0]  sh3;
  logic [ACC_W-1:0] acc;
  logic             ovf_q;
  logic             v4;
  logic [ACC_W-1:0] o_q;

  logic adv;
  assign adv       = ~(v4 & ~out_ready);
  assign in_ready  = adv;
  assign out_valid = v4;
  assign O         = o_q;
  assign OVF       = ovf_q;

  logic [P_W-1:0] pp;
  generate
    if (SG) begin : g_smul
      assign pp = $signed(s1.a) * $signed(s1.b);
    end else begin : g_umul
      assign pp = s1.a * s1.b;
    end
  endgenerate

  logic [ACC_W-1:0] p_ext;
  assign p_ext = {{(ACC_W-P_W){SG & pp[P_W-1]}}, pp};

  logic [ACC_W-1:0] lhs, rhs;
  logic [X_W-1:0]   lx, rx, res;
  logic             ov_now;
  logic [ACC_W-1:0] res_q;

  always_comb begin
    lhs = s2.op[1] ? (s2.clr ? '0 : acc) : s2.p;
    rhs = s2.op[1] ? s2.p : s2.c;
    lx  = {{2{SG & lhs[ACC_W-1]}}, lhs};
    rx  = {{2{SG & rhs[ACC_W-1]}}, rhs};
    res = s2.op[0] ? (lx - rx) : (lx + rx);
    if (SG)
      ov_now = ~((res[X_W-1] == res[ACC_W]) &&
                 (res[ACC_W] == res[ACC_W-1]));
    else
      ov_now = res[X_W-1] | res[ACC_W];
    res_q = res[ACC_W-1:0];
    if (SAT && ov_now) begin
      if (SG)
        res_q = res[X_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
      else
        res_q = res[X_W-1] ? '0 : '1;
    end
  end

  // Half-LSB bias: (1<<s)>>1 is zero for s=0, so no special case.
  logic [ACC_W:0]        one_w, rnd, r;
  logic signed [ACC_W:0] rs;
  logic [ACC_W:0]        ars, lrs, shd;

  always_comb begin
    one_w = {{ACC_W{1'b0}}, 1'b1};
    rnd   = RND ? ((one_w << sh3) >> 1) : '0;
    r     = {SG & acc[ACC_W-1], acc} + rnd;
    rs    = r;
    ars   = rs >>> sh3;
    lrs   = r >> sh3;
    shd   = SG ? ars : lrs;
  end

  always_ff @(posedge CLK or posedge a_RST) begin
    if (a_RST) begin
      s1    <= '0;
      s2    <= '0;
      v3    <= 1'b0;
      sh3   <= '0;
      acc   <= '0;
      ovf_q <= 1'b0;
      v4    <= 1'b0;
      o_q   <= '0;
    end else if (adv) begin
      s1.v   <= in_valid;
      s1.a   <= A;
      s1.b   <= B;
      s1.c   <= C;
      s1.op  <= OP;
      s1.clr <= CLR;
      s1.sh  <= SH;

      s2.v   <= s1.v;
      s2.p   <= p_ext;
      s2.c   <= s1.c;
      s2.op  <= s1.op;
      s2.clr <= s1.clr;
      s2.sh  <= s1.sh;

      v3  <= s2.v;
      sh3 <= s2.sh;
      if (s2.v) begin
        acc   <= res_q;
        ovf_q <= s2.clr ? ov_now : (ovf_q | ov_now);
      end

      v4 <= v3;
      if (v3)
        o_q <= shd[ACC_W-1:0];
    end
  end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe: directed vectors and stream sequences for dsp_mac_pipe,
// with a ROUND=0 twin sharing the same stimulus.
module tb_dsp_mac_pipe;

  logic        CLK = 1'b0;
  logic        a_RST = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  A = '0, B = '0;
  logic [23:0] C = '0;
  logic [1:0]  OP = '0;
  logic        CLR = 1'b0;
  logic [3:0]  SH = '0;
  logic        out_ready = 1'b1;

  logic        ir, ov, ovf;
  logic        ir_t, ov_t, ovf_t;
  logic [23:0] o, o_t;

  always #5 CLK = ~CLK;

  dsp_mac_pipe dut (
    .CLK(CLK), .a_RST(a_RST),
    .in_valid(in_valid), .in_ready(ir),
    .A(A), .B(B), .C(C), .OP(OP), .CLR(CLR), .SH(SH),
    .out_valid(ov), .out_ready(out_ready),
    .O(o), .OVF(ovf)
  );

  dsp_mac_pipe #(.ROUND(0)) dut_t (
    .CLK(CLK), .a_RST(a_RST),
    .in_valid(in_valid), .in_ready(ir_t),
    .A(A), .B(B), .C(C), .OP(OP), .CLR(CLR), .SH(SH),
    .out_valid(ov_t), .out_ready(out_ready),
    .O(o_t), .OVF(ovf_t)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic [23:0] c, input logic [1:0] op,
                       input logic clr, input logic [3:0] sh);
    A = a; B = b; C = c; OP = op; CLR = clr; SH = sh;
  endtask

  task automatic run_beat(input logic [7:0] a, input logic [7:0] b,
                          input logic [23:0] c, input logic [1:0] op,
                          input logic clr, input logic [3:0] sh,
                          output int lat);
    @(negedge CLK);
    drive(a, b, c, op, clr, sh);
    in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    lat = 9;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK);
      #1;
      if (ov) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [23:0] c;
    logic [1:0]  op;
    logic        clr;
    logic [3:0]  sh;
    logic [23:0] o;
    logic [23:0] ot;
    logic        ovf;
  } vec_t;

  vec_t vt[10];
  int   lat;

  initial begin
    vt[0] = '{8'hFD, 8'h05, 24'd10, 2'b00, 1'b1, 4'd0,
              24'hFFFFFB, 24'hFFFFFB, 1'b0};
    vt[1] = '{8'hFD, 8'h05, 24'd10, 2'b01, 1'b0, 4'd0,
              24'hFFFFE7, 24'hFFFFE7, 1'b0};
    vt[2] = '{8'h07, 8'h01, 24'd0, 2'b00, 1'b0, 4'd2,
              24'h000002, 24'h000001, 1'b0};
    vt[3] = '{8'hF9, 8'h01, 24'd0, 2'b00, 1'b0, 4'd2,
              24'hFFFFFE, 24'hFFFFFE, 1'b0};
    vt[4] = '{8'h00, 8'h00, 24'h7FFFFF, 2'b00, 1'b0, 4'd15,
              24'h000100, 24'h0000FF, 1'b0};
    vt[5] = '{8'h03, 8'h04, 24'd0, 2'b11, 1'b1, 4'd0,
              24'hFFFFF4, 24'hFFFFF4, 1'b0};
    vt[6] = '{8'h02, 8'h02, 24'd0, 2'b11, 1'b0, 4'd0,
              24'hFFFFF0, 24'hFFFFF0, 1'b0};
    vt[7] = '{8'h80, 8'h7F, 24'h7FFFFF, 2'b01, 1'b0, 4'd0,
              24'h800000, 24'h800000, 1'b1};
    vt[8] = '{8'h00, 8'h00, 24'd0, 2'b10, 1'b0, 4'd0,
              24'h800000, 24'h800000, 1'b1};
    vt[9] = '{8'h01, 8'h01, 24'd0, 2'b10, 1'b1, 4'd0,
              24'h000001, 24'h000001, 1'b0};

    #1;
    chk("rst_o", o, 0);
    chk("rst_ov", ov, 0);
    chk("rst_ir", ir, 1);
    repeat (2) @(negedge CLK);
    a_RST = 1'b0;

    // Reset in the middle of a stalled stream.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      drive($urandom, $urandom, $urandom, $urandom, 1'b0, 4'd0);
      in_valid = 1'b1;
    end
    @(negedge CLK);
    chk("pre_rst_ov", ov, 1);
    chk("pre_rst_ir", ir, 0);
    #2 a_RST = 1'b1;
    #1;
    chk("mid_rst_o", o, 0);
    chk("mid_rst_ov", ov, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_ir", ir, 1);
    @(negedge CLK);
    in_valid = 1'b0;
    out_ready = 1'b1;
    a_RST = 1'b0;
    run_beat(8'd2, 8'd3, 24'd0, 2'b10, 1'b0, 4'd0, lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_o", o, 24'd6);
    chk("post_rst_ot", o_t, 24'd6);

    for (int i = 0; i < 10; i++) begin
      run_beat(vt[i].a, vt[i].b, vt[i].c, vt[i].op,
               vt[i].clr, vt[i].sh, lat);
      chk($sformatf("v%0d_lat", i), lat, 3);
      chk($sformatf("v%0d_o", i), o, vt[i].o);
      chk($sformatf("v%0d_ot", i), o_t, vt[i].ot);
      chk($sformatf("v%0d_ovf", i), ovf, vt[i].ovf);
    end

    // Positive saturation then CLR recovery.
    run_beat(8'd0, 8'd0, 24'h7FFF00, 2'b00, 1'b0, 4'd0, lat);
    chk("seed_o", o, 24'h7FFF00);
    run_beat(8'd127, 8'd127, 24'd0, 2'b10, 1'b0, 4'd0, lat);
    chk("sat_o", o, 24'h7FFFFF);
    chk("sat_ovf", ovf, 1);
    run_beat(8'd1, 8'd1, 24'd0, 2'b10, 1'b1, 4'd0, lat);
    chk("clr_o", o, 24'd1);
    chk("clr_ovf", ovf, 0);

    // Back-to-back accumulate.
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge CLK);
      if (cyc >= 4) begin
        chk($sformatf("acc%0d_v", cyc - 4), ov, 1);
        chk($sformatf("acc%0d_o", cyc - 4), o, 100 * (cyc - 3));
      end
      if (cyc < 4) begin
        drive(8'd10, 8'd10, 24'd0, 2'b10, cyc == 0, 4'd0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end

    // Backpressure: 6 running-sum beats, 3-cycle stall.
    begin
      int          sent, rcv, stall_left;
      logic        seen, held, rdy_q;
      logic [23:0] o_hold;
      logic [23:0] exp_q[6];
      exp_q = '{24'd1, 24'd3, 24'd6, 24'd10, 24'd15, 24'd21};
      sent = 0; rcv = 0; stall_left = 0;
      seen = 1'b0; held = 1'b0; rdy_q = 1'b1; o_hold = '0;
      @(negedge CLK);
      for (int cyc = 0; cyc < 60; cyc++) begin
        @(posedge CLK);
        #1;
        if (in_valid && rdy_q) sent++;
        in_valid = (sent < 6);
        drive(8'd1, 8'(sent + 1), 24'd0, 2'b10, sent == 0, 4'd0);
        if (ov && !seen) begin
          seen = 1'b1;
          stall_left = 3;
        end
        out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        #1;
        rdy_q = ir;
        if (ov && !out_ready) begin
          chk("bp_ir", ir, 0);
          if (held) chk("bp_hold", o, o_hold);
          o_hold = o;
          held = 1'b1;
        end else begin
          held = 1'b0;
        end
        if (rcv > 0 && rcv < 6 && !ov)
          chk("bp_gap", ov, 1);
        if (ov && out_ready) begin
          chk($sformatf("bp%0d_o", rcv), o, exp_q[rcv]);
          rcv++;
        end
        if (rcv == 6) break;
      end
      chk("bp_count", rcv, 6);
      @(negedge CLK);
      in_valid = 1'b0;
      out_ready = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
